// File: rtl/rfmt_control_sequencer_pkg.sv
// Shared definitions for the register-format control sequencer: IR field layout,
// opcodes, FSM state encoding and one-hot ALU strobe bit positions.
package rfmt_control_sequencer_pkg;

    localparam int NUM_REGS = 16;
    localparam int ALU_OPS  = 14;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_SHR  = 4;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_ROR  = 7;
    localparam int ALU_ROL  = 8;
    localparam int ALU_NEG  = 9;
    localparam int ALU_NOT  = 10;
    localparam int ALU_MUL  = 11;
    localparam int ALU_DIV  = 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T4U,
        S_T5,
        S_T6,
        S_ILLEGAL
    } state_t;

    // Bit 13 of the strobe vector is reserved and never set.
    function automatic logic [ALU_OPS-1:0] alu_strobe(input logic [4:0] op);
        logic [ALU_OPS-1:0] s;
        s = '0;
        case (op)
            OP_ADD:  s[ALU_ADD]  = 1'b1;
            OP_SUB:  s[ALU_SUB]  = 1'b1;
            OP_AND:  s[ALU_AND]  = 1'b1;
            OP_OR:   s[ALU_OR]   = 1'b1;
            OP_SHR:  s[ALU_SHR]  = 1'b1;
            OP_SHRA: s[ALU_SHRA] = 1'b1;
            OP_SHL:  s[ALU_SHL]  = 1'b1;
            OP_ROR:  s[ALU_ROR]  = 1'b1;
            OP_ROL:  s[ALU_ROL]  = 1'b1;
            OP_NEG:  s[ALU_NEG]  = 1'b1;
            OP_NOT:  s[ALU_NOT]  = 1'b1;
            OP_MUL:  s[ALU_MUL]  = 1'b1;
            OP_DIV:  s[ALU_DIV]  = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic op_is_legal(input logic [4:0] op);
        return alu_strobe(op) != '0;
    endfunction

    function automatic logic op_is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rfmt_control_sequencer_reg_decoder_4to16.sv
// 4-bit register index plus enable to one-hot register strobe vector.
module reg_decoder_4to16
    import rfmt_control_sequencer_pkg::*;
(
    input  logic [3:0]          i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_idx == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/rfmt_control_sequencer.sv
// Moore control FSM: fetches one instruction per start and sequences the
// bus/register/ALU enables for register-format ALU instructions.
module rfmt_control_sequencer
    import rfmt_control_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_done,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [ALU_OPS-1:0]  alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_done;
    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [3:0]  w_rout_idx;
    logic        w_rout_en;
    logic        w_rout_sel_rc;
    logic        w_rin_en;
    logic        w_final;
    logic        w_unused;

    assign w_op     = IR[OP_MSB:OP_LSB];
    assign w_ra     = IR[RA_MSB:RA_LSB];
    assign w_rb     = IR[RB_MSB:RB_LSB];
    assign w_rc     = IR[RC_MSB:RC_LSB];
    assign w_unused = ^IR[RC_LSB-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_final;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        PCout         = 1'b0;
        MARin         = 1'b0;
        IncPC         = 1'b0;
        Zin           = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        PCin          = 1'b0;
        Read          = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        IRin          = 1'b0;
        Yin           = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        alu_op        = '0;
        w_rout_en     = 1'b0;
        w_rout_sel_rc = 1'b0;
        w_rin_en      = 1'b0;
        w_final       = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                w_state_next = S_T1;
            end
            S_T1: begin
                // PC reload repeats harmlessly while memory is still busy.
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_done) w_state_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_state_next = S_T3;
            end
            S_T3: begin
                if (!op_is_legal(w_op)) begin
                    w_state_next = S_ILLEGAL;
                end else if (op_is_unary(w_op)) begin
                    w_rout_en = 1'b1; alu_op = alu_strobe(w_op); Zin = 1'b1;
                    w_state_next = S_T4U;
                end else begin
                    w_rout_en = 1'b1; Yin = 1'b1;
                    w_state_next = S_T4;
                end
            end
            S_T4U: begin
                Zlowout = 1'b1; w_rin_en = 1'b1; w_final = 1'b1;
                w_state_next = S_IDLE;
            end
            S_T4: begin
                w_rout_en = 1'b1; w_rout_sel_rc = 1'b1;
                alu_op = alu_strobe(w_op); Zin = 1'b1;
                w_state_next = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_is_muldiv(w_op)) begin
                    LOin = 1'b1;
                    w_state_next = S_T6;
                end else begin
                    w_rin_en = 1'b1; w_final = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1; w_final = 1'b1;
                w_state_next = S_IDLE;
            end
            S_ILLEGAL: w_state_next = S_ILLEGAL;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_rout_idx = w_rout_sel_rc ? w_rc : w_rb;
    assign busy       = (r_state != S_IDLE) && (r_state != S_ILLEGAL);
    assign illegal    = (r_state == S_ILLEGAL);
    assign done       = r_done;

    reg_decoder_4to16 u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    reg_decoder_4to16 u_rin_dec (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule

// File: tb/tb_rfmt_control_sequencer.sv
// Directed bench for rfmt_control_sequencer with a small bus datapath model
// that reacts to the strobes so register results can be checked end to end.
module tb_rfmt_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, mem_done;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
    logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [13:0] alu_op;
    logic        busy, done, illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_MARIN  = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_ZIN    = 14'h0400;
    localparam logic [13:0] S_ZLOW   = 14'h0200;
    localparam logic [13:0] S_ZHIGH  = 14'h0100;
    localparam logic [13:0] S_PCIN   = 14'h0080;
    localparam logic [13:0] S_READ   = 14'h0040;
    localparam logic [13:0] S_MDRIN  = 14'h0020;
    localparam logic [13:0] S_MDROUT = 14'h0010;
    localparam logic [13:0] S_IRIN   = 14'h0008;
    localparam logic [13:0] S_YIN    = 14'h0004;
    localparam logic [13:0] S_HIIN   = 14'h0002;
    localparam logic [13:0] S_LOIN   = 14'h0001;

    localparam logic [13:0] T0S = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [13:0] T1S = S_ZLOW | S_PCIN | S_READ | S_MDRIN;
    localparam logic [13:0] T2S = S_MDROUT | S_IRIN;

    localparam logic [13:0] A_AND = 14'h0004;
    localparam logic [13:0] A_NOT = 14'h0400;
    localparam logic [13:0] A_MUL = 14'h0800;

    logic [13:0] strobes;
    assign strobes = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                      Read, MDRin, MDRout, IRin, Yin, HIin, LOin};

    always #5 clock = ~clock;

    rfmt_control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .mem_done(mem_done), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal)
    );

    // Datapath model: registers, Y, Z (64-bit), HI, LO on a single shared bus.
    logic [31:0] m_r [16];
    logic [31:0] m_y, m_lo, m_hi, m_bus;
    logic [63:0] m_z;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;

    always_comb begin
        m_bus = '0;
        for (int i = 0; i < 16; i++) if (Rout[i]) m_bus = m_r[i];
        if (Zlowout)  m_bus = m_z[31:0];
        if (Zhighout) m_bus = m_z[63:32];
    end

    always @(posedge clock) begin
        if (ld_en) m_r[ld_idx] <= ld_val;
        for (int j = 0; j < 16; j++) if (Rin[j]) m_r[j] <= m_bus;
        if (Yin) m_y <= m_bus;
        if (Zin) begin
            case (alu_op)
                A_AND:   m_z <= {32'h0, m_y & m_bus};
                A_MUL:   m_z <= {32'h0, m_y} * {32'h0, m_bus};
                A_NOT:   m_z <= {32'h0, ~m_bus};
                default: ;
            endcase
        end
        if (LOin) m_lo <= m_bus;
        if (HIin) m_hi <= m_bus;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [13:0] e_s,
                              input logic [15:0] e_rin, input logic [15:0] e_rout,
                              input logic [13:0] e_alu, input logic e_busy,
                              input logic e_done, input logic e_ill);
        logic [62:0] obs, exp;
        obs = {strobes, Rin, Rout, alu_op, busy, done, illegal};
        exp = {e_s, e_rin, e_rout, e_alu, e_busy, e_done, e_ill};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("cycle %s strobes=%h Rin=%h Rout=%h alu=%h busy=%b done=%b ill=%b",
                 tag, strobes, Rin, Rout, alu_op, busy, done, illegal);
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("datapath %s value=%h", tag, obs);
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_done = 1'b0; IR = '0;
        ld_en = 1'b0; ld_idx = '0; ld_val = '0;
        tick(); tick();
        expect_out("reset", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();
        expect_out("idle", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);

        // AND R2,R5,R6 with memory ready
        load(4'd5, 32'h34); load(4'd6, 32'h45);
        IR = 32'h112B0000; mem_done = 1'b1; start = 1'b1;
        tick(); expect_out("and_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); expect_out("and_t1", T1S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("and_t2", T2S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("and_t3", S_YIN, 16'h0, 16'h0020, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("and_t4", S_ZIN, 16'h0, 16'h0040, A_AND, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("and_t5", S_ZLOW, 16'h0004, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("and_done", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);
        check_word("and_r2", m_r[2], 32'h04);
        tick(); expect_out("and_idle", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);

        // Same instruction with three memory wait cycles
        mem_done = 1'b0; start = 1'b1;
        tick(); expect_out("ws_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); expect_out("ws_t1", T1S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
            if (k == 3) mem_done = 1'b1;
        end
        tick(); expect_out("ws_t2", T2S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ws_t3", S_YIN, 16'h0, 16'h0020, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ws_t4", S_ZIN, 16'h0, 16'h0040, A_AND, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ws_t5", S_ZLOW, 16'h0004, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ws_done", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);

        // MUL R1,R2: 0x00010000 * 0x00030002 = 0x00000003_00020000
        load(4'd1, 32'h0001_0000); load(4'd2, 32'h0003_0002);
        IR = 32'h70090000; start = 1'b1;
        tick(); expect_out("mul_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); expect_out("mul_t1", T1S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_t2", T2S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_t3", S_YIN, 16'h0, 16'h0002, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_t4", S_ZIN, 16'h0, 16'h0004, A_MUL, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_t5", S_ZLOW | S_LOIN, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_t6", S_ZHIGH | S_HIIN, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("mul_done", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);
        check_word("mul_lo", m_lo, 32'h0002_0000);
        check_word("mul_hi", m_hi, 32'h0000_0003);

        // NOT R3,R7
        load(4'd7, 32'h0F0F_00FF);
        IR = 32'h89B80000; start = 1'b1;
        tick(); expect_out("not_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); expect_out("not_t1", T1S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("not_t2", T2S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("not_t3", S_ZIN, 16'h0, 16'h0080, A_NOT, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("not_t4u", S_ZLOW, 16'h0008, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("not_done", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);
        check_word("not_r3", m_r[3], 32'hF0F0_FF00);

        // Illegal opcode 31
        IR = 32'hF8000000; start = 1'b1;
        tick(); expect_out("ill_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); expect_out("ill_t1", T1S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ill_t2", T2S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ill_t3", 14'h0, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("ill_state", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick(); tick();
        expect_out("ill_sticky", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b1);
        clear = 1'b1; start = 1'b0;
        tick(); expect_out("ill_clear", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick(); expect_out("ill_idle", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);

        // Clear while in T4 aborts with no register write
        load(4'd2, 32'h0000_1111);
        IR = 32'h112B0000; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        expect_out("clr_t4", S_ZIN, 16'h0, 16'h0040, A_AND, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick(); expect_out("clr_abort", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick(); expect_out("clr_idle", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b0, 1'b0);
        check_word("clr_r2", m_r[2], 32'h0000_1111);

        // Back-to-back: start held through the done cycle
        IR = 32'h89B80000; start = 1'b1;
        tick(); tick(); tick(); tick();
        tick(); expect_out("b2b_t4u", S_ZLOW, 16'h0008, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("b2b_done", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);
        tick(); expect_out("b2b_t0", T0S, 16'h0, 16'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); expect_out("b2b_done2", 14'h0, 16'h0, 16'h0, 14'h0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
